load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle data-memory interface for the RV32I core, downstream of the datapath's ALUResult/WriteData.
//  Turns a load/store into a word-aligned bus transaction with byte strobes and a req/gnt/rvalid handshake.
//  Sign/zero-extends load data and stalls the core until the access retires.
//  Detects misaligned/illegal accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT_CYCLES  256  cycles in REQ+WAIT before the access is aborted with BusError (>=2)
// PORTS
//  clk         in   1   core clock, all state on posedge
//  reset_n     in   1   asynchronous, active-low reset
//  MemRead     in   1   load request from decode (held while Stall=1)
//  MemWrite    in   1   store request from decode (held while Stall=1)
//  Funct3      in   3   Instr[14:12]: access size/sign
//  ALUResult   in   32  byte address
//  WriteData   in   32  store data (rs2), low bytes significant
//  ReadData    out  32  extended load result, valid in DONE
//  Stall       out  1   freeze PC/pipeline this cycle
//  Fault       out  1   1-cycle pulse: misaligned or illegal Funct3; no bus access made
//  BusError    out  1   1-cycle pulse in DONE when the access timed out
//  BusReq      out  1   bus request, held until BusGnt
//  BusWe       out  1   1=write
//  BusAddr     out  32  {ALUResult[31:2],2'b00}
//  BusWStrb    out  4   byte enables (writes only, 0 on reads)
//  BusWData    out  32  lane-replicated store data
//  BusGnt      in   1   address phase accepted
//  BusRValid   in   1   read data valid (>=1 cycle after BusGnt)
//  BusRData    in   32  read word
// BEHAVIOUR
//  Reset: state IDLE, timer 0; BusReq/BusWe/BusAddr/BusWStrb/BusWData/ReadData/Fault/BusError = 0.
//  Reset mid-access drops BusReq asynchronously; the bus must tolerate the abandoned transaction.
//  Access = MemRead|MemWrite; if both are set, the store wins.
//  Legal Funct3: loads 000 LB,001 LH,010 LW,100 LBU,101 LHU; stores 000 SB,001 SH,010 SW.
//  Misaligned: H with addr[0]=1, W with addr[1:0]!=0.
//  FSM (bus outputs registered):
//   IDLE: legal access -> REQ, latch addr/size/we/strb/wdata, BusReq=1 next cycle.
//         illegal access -> Fault=1 (combinational), stay IDLE, Stall=0, ReadData unchanged.
//   REQ:  BusReq=1. On BusGnt, BusReq drops next cycle: write -> DONE, read -> WAIT.
//   WAIT: on BusRValid capture the extended lane into ReadData -> DONE.
//   DONE: Stall=0 so the core retires; -> IDLE unconditionally.
//         Back-to-back accesses restart from IDLE in the next cycle.
//  Stall = Access & legal & (state!=DONE), combinational; during reset it follows the inputs, state=IDLE.
//  Timeout: timer counts cycles in REQ/WAIT and clears in IDLE.
//   At TIMEOUT_CYCLES-1 -> DONE with BusError=1, ReadData=0, BusReq dropped.
//   A late BusRValid is ignored.
//  Min latency (zero-wait bus), request seen at cycle N:
//   read: REQ N+1, WAIT N+2, DONE N+3 (3 stall cycles).
//   write: REQ N+1, DONE N+2 (2 stall cycles).
//  Strobes: SB 4'b0001<<a[1:0]; SH 4'b0011<<{a[1],1'b0}; SW 4'b1111.
//  BusWData: SB {4{b}}, SH {2{h}}, SW w.
//  Loads: lane select by a[1:0]; B/H sign-extend, BU/HU zero-extend.
//  Inputs are sampled only in IDLE; changes while stalled are ignored until DONE.
// STRUCTURE
//  lsu_pkg: lsu_state_e {IDLE,REQ,WAIT,DONE}; funct3 constants F3_B/H/W/BU/HU; align check function.
//  Sub-module lsu_align (combinational): Funct3 + addr + data -> strobes, replicated wdata, extended rdata.
//  Top holds the FSM, timeout counter and registered bus outputs.
// TESTING
//  1 LW 0x100, Gnt at once, RValid+1, RData=0xDEADBEEF -> Stall 3 cycles, ReadData=0xDEADBEEF in DONE.
//  2 LB 0x103, RData=0x80FFFFFF -> ReadData=0xFFFFFF80; LBU -> 0x00000080.
//  3 SH 0x102, WriteData=0x1234ABCD, Gnt delayed 5 cycles -> BusReq held 5 cycles, BusWStrb=4'b1100, BusWData=0xABCDABCD.
//  4 LW 0x101 -> Fault=1 for 1 cycle, BusReq never rises, Stall=0.
//  5 LW with no BusRValid, TIMEOUT_CYCLES=8 -> BusError in DONE, ReadData=0, FSM back in IDLE.
//  6 reset_n low during WAIT -> BusReq=0 and state IDLE immediately; next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and helpers for the RV32I load/store unit:
//               FSM state encoding, Funct3 access-size constants and the
//               legality/alignment check used by the top level.
// Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // 1 when the access is a legal Funct3 for its direction and the byte
    // address is naturally aligned for the access size.
    function automatic logic lsu_access_ok(input logic       is_store,
                                           input logic [2:0] f3,
                                           input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane logic for the load/store unit.
//               Produces byte strobes and lane-replicated store data from the
//               access size and address, and extracts/extends the selected
//               lane of a bus read word.
//   funct3_i  in  3   access size/sign (Instr[14:12])
//   addr_i    in  2   low byte-address bits
//   wdata_i   in  32  store data, low bytes significant
//   rdata_i   in  32  raw bus read word
//   wstrb_o   out 4   byte enables for the access size/offset
//   wdata_o   out 32  store data replicated across lanes
//   rdata_o   out 32  sign/zero-extended load result
// Revision    : 1.0  initial release
// ============================================================================
module lsu_align (
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] w_byte_lane;
    logic [31:0] w_half_lane;
    logic        w_sext;

    // Shift the addressed byte/halfword down to bit 0.
    assign w_byte_lane = rdata_i >> {addr_i, 3'b000};
    assign w_half_lane = rdata_i >> {addr_i[1], 4'b0000};
    // Funct3[2] set means the unsigned (BU/HU) flavour.
    assign w_sext      = ~funct3_i[2];

    always_comb begin
        wstrb_o = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                wstrb_o = 4'b0001 << addr_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{w_sext & w_byte_lane[7]}}, w_byte_lane[7:0]};
            end
            2'b01: begin
                wstrb_o = 4'b0011 << {addr_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{w_sext & w_half_lane[15]}}, w_half_lane[15:0]};
            end
            default: begin
                wstrb_o = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Multi-cycle data-memory interface for the RV32I core.
//               Converts a load/store into a word-aligned bus transaction
//               (req/gnt/rvalid), extends load data, stalls the core until the
//               access retires, and flags illegal/misaligned accesses and bus
//               timeouts.
//   clk        in   1   core clock
//   reset_n    in   1   asynchronous active-low reset
//   MemRead    in   1   load request (held while Stall)
//   MemWrite   in   1   store request (held while Stall); wins over MemRead
//   Funct3     in   3   access size/sign
//   ALUResult  in   32  byte address
//   WriteData  in   32  store data
//   ReadData   out  32  extended load result, valid in DONE
//   Stall      out  1   freeze PC/pipeline
//   Fault      out  1   illegal/misaligned access pulse, no bus access
//   BusError   out  1   timeout pulse in DONE
//   BusReq/BusWe/BusAddr/BusWStrb/BusWData  out  registered bus request
//   BusGnt/BusRValid/BusRData               in   bus responses
// Revision    : 1.0  initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Fault,
    output logic        BusError,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [3:0]  BusWStrb,
    output logic [31:0] BusWData,
    input  logic        BusGnt,
    input  logic        BusRValid,
    input  logic [31:0] BusRData
);

    localparam int            TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    lsu_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          bus_req_q;
    logic          bus_we_q;
    logic [31:0]   bus_addr_q;
    logic [3:0]    bus_wstrb_q;
    logic [31:0]   bus_wdata_q;
    logic [31:0]   read_data_q;
    logic          bus_err_q;
    logic [2:0]    f3_q;
    logic [1:0]    addr_lo_q;

    logic          w_access;
    logic          w_legal;
    logic          w_start;
    logic          w_timeout;
    logic [2:0]    w_f3;
    logic [1:0]    w_addr_lo;
    logic [3:0]    w_wstrb;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rdata_ext;

    assign w_access  = MemRead | MemWrite;
    assign w_legal   = lsu_access_ok(MemWrite, Funct3, ALUResult[1:0]);
    assign w_start   = (state_q == IDLE) & w_access & w_legal;
    assign w_timeout = ((state_q == REQ) || (state_q == WAIT)) && (timer_q == TIMER_LAST);

    // One lane unit serves both directions: in IDLE it sees the live request
    // (strobes/wdata to latch), afterwards the latched size/offset so that
    // read data is extended with the values captured at issue time.
    assign w_f3      = (state_q == IDLE) ? Funct3         : f3_q;
    assign w_addr_lo = (state_q == IDLE) ? ALUResult[1:0] : addr_lo_q;

    lsu_align u_align (
        .funct3_i (w_f3),
        .addr_i   (w_addr_lo),
        .wdata_i  (WriteData),
        .rdata_i  (BusRData),
        .wstrb_o  (w_wstrb),
        .wdata_o  (w_wdata),
        .rdata_o  (w_rdata_ext)
    );

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        case (state_q)
            IDLE: begin
                if (w_start) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                timer_d = timer_q + TIMER_ONE;
                if (w_timeout) begin
                    state_d = DONE;
                    timer_d = '0;
                end else if (BusGnt) begin
                    state_d = bus_we_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_q + TIMER_ONE;
                if (w_timeout) begin
                    state_d = DONE;
                    timer_d = '0;
                end else if (BusRValid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wstrb_q <= '0;
            bus_wdata_q <= '0;
            read_data_q <= '0;
            bus_err_q   <= 1'b0;
            f3_q        <= '0;
            addr_lo_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            // Set on the edge into DONE, so it is high for exactly the DONE cycle.
            bus_err_q <= w_timeout;

            if (w_start) begin
                bus_req_q   <= 1'b1;
                bus_we_q    <= MemWrite;
                bus_addr_q  <= {ALUResult[31:2], 2'b00};
                bus_wstrb_q <= MemWrite ? w_wstrb : 4'b0000;
                bus_wdata_q <= MemWrite ? w_wdata : 32'h0;
                f3_q        <= Funct3;
                addr_lo_q   <= ALUResult[1:0];
            end else if ((state_q == REQ) && (BusGnt || w_timeout)) begin
                bus_req_q <= 1'b0;
            end

            if (w_timeout) begin
                read_data_q <= '0;
            end else if ((state_q == WAIT) && BusRValid) begin
                read_data_q <= w_rdata_ext;
            end
        end
    end

    assign Stall    = w_access & w_legal & (state_q != DONE);
    assign Fault    = (state_q == IDLE) & w_access & ~w_legal;
    assign BusError = bus_err_q;
    assign BusReq   = bus_req_q;
    assign BusWe    = bus_we_q;
    assign BusAddr  = bus_addr_q;
    assign BusWStrb = bus_wstrb_q;
    assign BusWData = bus_wdata_q;
    assign ReadData = read_data_q;

endmodule
`default_nettype wire
